// File: rtl/mux4_scan_ctrl_if.sv
// Handshake bundle between the scan controller and its host/mux side.
// The slave modport belongs to mux4_scan_ctrl; the master modport belongs to whoever drives it.
interface mux4_scan_ctrl_if #(
    parameter int DWELL_W = 4
);
    logic               start;
    logic               stop;
    logic [3:0]         en_mask;
    logic [DWELL_W-1:0] dwell;
    logic               mux_out;
    logic [1:0]         sel;
    logic               busy;
    logic               sample_valid;
    logic [1:0]         sample_ch;
    logic               sample_bit;
    logic               frame_done;
    logic [3:0]         frame_data;

    modport master (
        output start, stop, en_mask, dwell, mux_out,
        input  sel, busy, sample_valid, sample_ch, sample_bit, frame_done, frame_data
    );

    modport slave (
        input  start, stop, en_mask, dwell, mux_out,
        output sel, busy, sample_valid, sample_ch, sample_bit, frame_done, frame_data
    );
endinterface

// File: rtl/mux4_scan_ctrl.sv
// Select sequencer for a 4:1 single-bit mux: steps sel over the enabled channels,
// dwells on each, samples the mux output and assembles a 4-bit frame.
module mux4_scan_ctrl #(
    parameter int DWELL_W = 4
) (
    input logic              clk,
    input logic              rst_n,
    mux4_scan_ctrl_if.slave  bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    logic [0:0]         state;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dwell_q;
    logic [3:0]         mask_q;
    logic               stop_pending;

    logic [1:0] start_ch;
    logic [1:0] next_sel;
    logic       last_ch;

    function automatic logic [1:0] lowest_ch(input logic [3:0] m);
        lowest_ch = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) lowest_ch = 2'(i);
        end
    endfunction

    // Next channel to visit and whether the current one closes the frame.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        start_ch = lowest_ch(bus.en_mask);
        next_sel = lowest_ch(mask_q);
        last_ch  = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(bus.sel))) begin
                next_sel = 2'(i);
                last_ch  = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side sees pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            dwell_q          <= '0;
            mask_q           <= '0;
            stop_pending     <= 1'b0;
            bus.sel          <= 2'd0;
            bus.busy         <= 1'b0;
            bus.sample_valid <= 1'b0;
            bus.sample_ch    <= 2'd0;
            bus.sample_bit   <= 1'b0;
            bus.frame_done   <= 1'b0;
            bus.frame_data   <= 4'd0;
        end else begin
            bus.sample_valid <= 1'b0;
            bus.frame_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && (bus.en_mask != 4'd0)) begin
                        mask_q         <= bus.en_mask;
                        dwell_q        <= bus.dwell;
                        cnt            <= bus.dwell;
                        bus.sel        <= start_ch;
                        bus.frame_data <= 4'd0;
                        bus.busy       <= 1'b1;
                        stop_pending   <= bus.stop;
                        state          <= SCAN;
                    end
                end
                SCAN: begin
                    if (bus.stop) stop_pending <= 1'b1;
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        bus.sample_valid        <= 1'b1;
                        bus.sample_ch           <= bus.sel;
                        bus.sample_bit          <= bus.mux_out;
                        bus.frame_data[bus.sel] <= bus.mux_out;
                        bus.sel                 <= next_sel;
                        cnt                     <= dwell_q;
                        if (last_ch) begin
                            bus.frame_done <= 1'b1;
                            // A stop seen at any point in the frame ends the scan here.
                            if (stop_pending || bus.stop) begin
                                state        <= IDLE;
                                bus.busy     <= 1'b0;
                                bus.sel      <= 2'd0;
                                stop_pending <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Directed bench for mux4_scan_ctrl; a behavioural 4:1 mux closes the sel -> mux_out loop.
module tb_mux4_scan_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] mux_in = 4'd0;
    int tests = 0;
    int fails = 0;

    mux4_scan_ctrl_if #(.DWELL_W(4)) bus ();

    mux4_scan_ctrl #(.DWELL_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    assign bus.mux_out = mux_in[bus.sel];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".busy"}, 32'(bus.busy), 32'd0);
        check({tag, ".sel"}, 32'(bus.sel), 32'd0);
        check({tag, ".sv"}, 32'(bus.sample_valid), 32'd0);
        check({tag, ".fd"}, 32'(bus.frame_done), 32'd0);
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.en_mask = 4'd0;
        bus.dwell   = 4'd0;
        #12;
        check_idle("rst");
        check("rst.ch", 32'(bus.sample_ch), 32'd0);
        check("rst.bit", 32'(bus.sample_bit), 32'd0);
        check("rst.data", 32'(bus.frame_data), 32'd0);
        rst_n = 1'b1;
        tick();

        // One frame, all channels, dwell 0, start and stop together.
        mux_in = 4'b0011; bus.en_mask = 4'b1111; bus.dwell = 4'd0;
        bus.start = 1'b1; bus.stop = 1'b1;
        tick();
        bus.start = 1'b0; bus.stop = 1'b0;
        check("t1.sel0", 32'(bus.sel), 32'd0);
        check("t1.busy", 32'(bus.busy), 32'd1);
        check("t1.sv0", 32'(bus.sample_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t1.sv%0d", i), 32'(bus.sample_valid), 32'd1);
            check($sformatf("t1.ch%0d", i), 32'(bus.sample_ch), 32'(i));
            check($sformatf("t1.bit%0d", i), 32'(bus.sample_bit), (i < 2) ? 32'd1 : 32'd0);
            check($sformatf("t1.fd%0d", i), 32'(bus.frame_done), (i == 3) ? 32'd1 : 32'd0);
            check($sformatf("t1.sel%0d", i), 32'(bus.sel), (i == 3) ? 32'd0 : 32'(i + 1));
        end
        check("t1.data", 32'(bus.frame_data), 32'b0011);
        check("t1.busy_end", 32'(bus.busy), 32'd0);
        tick();
        check_idle("t1.after");

        // Mask 1010, dwell 2, stop during the second channel.
        bus.en_mask = 4'b1010; bus.dwell = 4'd2; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("t2.sel_e0", 32'(bus.sel), 32'd1);
        check("t2.data_clr", 32'(bus.frame_data), 32'd0);
        tick(2);
        check("t2.sel_e2", 32'(bus.sel), 32'd1);
        check("t2.sv_e2", 32'(bus.sample_valid), 32'd0);
        tick();
        check("t2.sv_e3", 32'(bus.sample_valid), 32'd1);
        check("t2.ch_e3", 32'(bus.sample_ch), 32'd1);
        check("t2.bit_e3", 32'(bus.sample_bit), 32'd1);
        check("t2.fd_e3", 32'(bus.frame_done), 32'd0);
        check("t2.sel_e3", 32'(bus.sel), 32'd3);
        tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check("t2.sel_e5", 32'(bus.sel), 32'd3);
        check("t2.busy_e5", 32'(bus.busy), 32'd1);
        tick();
        check("t2.sv_e6", 32'(bus.sample_valid), 32'd1);
        check("t2.ch_e6", 32'(bus.sample_ch), 32'd3);
        check("t2.bit_e6", 32'(bus.sample_bit), 32'd0);
        check("t2.fd_e6", 32'(bus.frame_done), 32'd1);
        check("t2.data", 32'(bus.frame_data), 32'b0010);
        check("t2.busy_e6", 32'(bus.busy), 32'd0);
        tick();
        check_idle("t2.after");

        // Single channel 2, dwell 1; mux input changes mid-run; start in SCAN ignored.
        mux_in = 4'b0100; bus.en_mask = 4'b0100; bus.dwell = 4'd1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("t3.sel_e0", 32'(bus.sel), 32'd2);
        tick();
        check("t3.sv_e1", 32'(bus.sample_valid), 32'd0);
        tick();
        check("t3.sv_e2", 32'(bus.sample_valid), 32'd1);
        check("t3.fd_e2", 32'(bus.frame_done), 32'd1);
        check("t3.bit_e2", 32'(bus.sample_bit), 32'd1);
        check("t3.sel_e2", 32'(bus.sel), 32'd2);
        mux_in = 4'b0000; bus.start = 1'b1; bus.en_mask = 4'b1111; bus.dwell = 4'd0;
        tick();
        bus.start = 1'b0;
        check("t3.sv_e3", 32'(bus.sample_valid), 32'd0);
        check("t3.sel_e3", 32'(bus.sel), 32'd2);
        tick();
        check("t3.sv_e4", 32'(bus.sample_valid), 32'd1);
        check("t3.fd_e4", 32'(bus.frame_done), 32'd1);
        check("t3.bit_e4", 32'(bus.sample_bit), 32'd0);
        check("t3.sel_e4", 32'(bus.sel), 32'd2);
        check("t3.data_e4", 32'(bus.frame_data), 32'd0);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check("t3.busy_e5", 32'(bus.busy), 32'd1);
        tick();
        check("t3.busy_e6", 32'(bus.busy), 32'd0);

        // Start with an empty mask is ignored.
        bus.en_mask = 4'b0000; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_idle("t4.e0");
        tick(2);
        check_idle("t4.e2");

        // Continuous mode: frame_data carries over and is overwritten bit by bit.
        mux_in = 4'b1111; bus.en_mask = 4'b1111; bus.dwell = 4'd0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(4);
        check("t5.fd_e4", 32'(bus.frame_done), 32'd1);
        check("t5.data_e4", 32'(bus.frame_data), 32'b1111);
        check("t5.busy_e4", 32'(bus.busy), 32'd1);
        mux_in = 4'b0000;
        tick();
        check("t5.ch_e5", 32'(bus.sample_ch), 32'd0);
        check("t5.data_e5", 32'(bus.frame_data), 32'b1110);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        tick(2);
        check("t5.fd_e8", 32'(bus.frame_done), 32'd1);
        check("t5.data_e8", 32'(bus.frame_data), 32'd0);
        check("t5.busy_e8", 32'(bus.busy), 32'd0);
        tick();

        // Reset asserted during the channel-2 dwell clears everything at once.
        mux_in = 4'b1010; bus.en_mask = 4'b1111; bus.dwell = 4'd3; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(8);
        check("t6.ch_e8", 32'(bus.sample_ch), 32'd1);
        check("t6.sel_e8", 32'(bus.sel), 32'd2);
        check("t6.data_e8", 32'(bus.frame_data), 32'b0010);
        tick(2);
        rst_n = 1'b0;
        #1;
        check_idle("t6.rst");
        check("t6.rst_ch", 32'(bus.sample_ch), 32'd0);
        check("t6.rst_bit", 32'(bus.sample_bit), 32'd0);
        check("t6.rst_data", 32'(bus.frame_data), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        check_idle("t6.post");
        check("t6.post_data", 32'(bus.frame_data), 32'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("t6.restart_busy", 32'(bus.busy), 32'd1);
        check("t6.restart_sel", 32'(bus.sel), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mux4_scan_ctrl.md
Name: mux4_scan_ctrl

Overview:
Upstream select sequencer for the 4:1 single-bit multiplexer (4-bit `in`, 2-bit `sel`, 1-bit `out`).
- Steps `sel` through the enabled channels in ascending order, wrapping 3->0.
- Holds each channel for a programmable dwell, then samples the mux output.
- Assembles one bit per channel into a 4-bit frame, with per-sample and per-frame strobes.
- Runs continuously after `start`. Stops cleanly at a frame boundary after `stop`.

Parameters:
- DWELL_W, 4, width of dwell count. A channel is held for dwell+1 cycles.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin scanning; sampled only in IDLE.
- stop  input  1  request stop at end of current frame; sampled every cycle.
- en_mask  input  4  channel enable mask, bit i = channel i; latched on accepted start.
- dwell  input  DWELL_W  extra hold cycles per channel; latched on accepted start.
- mux_out  input  1  output of the downstream 4:1 mux.
- sel  output  2  select driven to the mux.
- busy  output  1  high while scanning.
- sample_valid  output  1  one-cycle pulse; a channel sample was captured.
- sample_ch  output  2  channel of the last sample.
- sample_bit  output  1  value of the last sample.
- frame_done  output  1  one-cycle pulse, coincident with sample_valid of the last enabled channel.
- frame_data  output  4  bit i = latest sample of channel i; disabled channels read 0.

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - sel=0, busy=0, sample_valid=0, sample_ch=0, sample_bit=0, frame_done=0, frame_data=0.
  - Internal dwell counter, latched mask, latched dwell and stop_pending all clear to 0.
- States: IDLE, SCAN.
- IDLE:
  - On start=1 with en_mask!=0: latch mask and dwell; sel <= lowest enabled channel; cnt <= dwell; frame_data <= 0; busy <= 1; go to SCAN.
  - stop_pending <= stop on that same edge. Start and stop together therefore give exactly one frame.
  - start with en_mask==0 is ignored; state stays IDLE.
- SCAN, each edge:
  - If stop=1, set stop_pending.
  - If cnt!=0: cnt decrements.
  - If cnt==0, capture:
    - sample_valid <= 1, sample_ch <= sel, sample_bit <= mux_out, frame_data[sel] <= mux_out.
    - sel <= next enabled channel above sel, wrapping; cnt <= latched dwell.
  - Last enabled channel = no enabled channel above current sel.
    - On its capture, frame_done <= 1.
    - If stop_pending is set, or stop=1 on that edge: go to IDLE, busy <= 0, sel <= 0, stop_pending <= 0. frame_data is retained.
- Strobes: sample_valid and frame_done are high exactly one cycle per event and 0 otherwise.
- Latency:
  - sel holds dwell+1 cycles per channel.
  - First capture occurs dwell+1 edges after the start edge.
  - Full frame takes N*(dwell+1) cycles, N = popcount(mask).
- Single enabled channel: sel never changes; every capture is also a frame_done.
- start while in SCAN is ignored. en_mask and dwell changes during SCAN are ignored until the next accepted start.
- New frame in continuous mode: frame_data is not cleared; each bit is overwritten as its channel is resampled.
- Reset asserted mid-dwell: outputs go to their reset values immediately, with no trailing strobe.

Test Plan:
- Mux in=4'b0011, mask=4'b1111, dwell=0, start pulse, stop in same cycle:
  - sel goes 0,1,2,3 one cycle each.
  - sample_bit 1,1,0,0; frame_done with ch3.
  - frame_data=4'b0011; busy drops; sel=0.
- in=4'b0011, mask=4'b1010, dwell=2, start, stop 5 cycles later:
  - sel=1 for 3 cycles, then 3 for 3 cycles.
  - Samples 1 then 0; frame_done once.
  - frame_data=4'b0010; return to IDLE after the first frame.
- mask=4'b0100, dwell=1, start, then in changes 0100->0000 mid-run:
  - sel constant at 2; every capture (every 2 cycles) pulses both strobes.
  - sample_bit tracks in[2].
- start with mask=0: busy stays 0, no strobes. Also assert start while in SCAN: no restart, sel sequence unaffected.
- Continuous run, mask=4'b1111, dwell=3; assert rst_n=0 during the ch2 dwell:
  - All outputs go to 0 asynchronously.
  - After release, block sits in IDLE until the next start.
